// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//   8N1 serial receiver (LSB first, idle high) with mid-bit sampling from a
//   single bit timer. Each good byte is held in data_out with a
//   ready/acknowledge handshake. Bad stop bits and lost bytes raise sticky
//   error flags.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per serial bit (4..65535)
//   CNT_W        : bit-timer width, 2**CNT_W > CLKS_PER_BIT
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   RxD        in   serial line, asynchronous to clk, idle high
//   rd_ack     in   consumer acknowledge, clears data_ready
//   data_out   out  last correctly received byte
//   data_ready out  data_out holds an unacknowledged byte
//   frame_err  out  sticky, bad stop bit seen
//   overrun    out  sticky, a byte was overwritten before being acknowledged
//   busy       out  a frame is in progress (state != IDLE)
// ---------------------------------------------------------------------------
module uart_receiver #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RxD,
    input  logic       rd_ack,
    output logic [7:0] data_out,
    output logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] timer, timer_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             armed, armed_nxt;
    logic             rx_meta, rx_s;
    logic             byte_done, frame_bad;

    // Two-flop synchronizer; reset to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RxD;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            armed   <= 1'b1;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
            armed   <= armed_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        armed_nxt   = armed;
        byte_done   = 1'b0;
        frame_bad   = 1'b0;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                // After a low stop bit the line may still be in a break;
                // wait for it to go high before accepting a new start edge.
                if (!armed) begin
                    if (rx_s) armed_nxt = 1'b1;
                end else if (!rx_s) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (timer == HALF_CNT) begin
                    timer_nxt = '0;
                    if (!rx_s) begin
                        bit_idx_nxt = '0;
                        state_nxt   = DATA;
                    end else begin
                        state_nxt = IDLE;   // too short to be a start bit
                    end
                end else begin
                    timer_nxt = timer + CNT_W'(1);
                end
            end
            DATA: begin
                if (timer == FULL_CNT) begin
                    timer_nxt          = '0;
                    shift_nxt[bit_idx] = rx_s;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                    else                 bit_idx_nxt = bit_idx + 3'd1;
                end else begin
                    timer_nxt = timer + CNT_W'(1);
                end
            end
            STOP: begin
                if (timer == FULL_CNT) begin
                    // Leaving on the stop midpoint lets a back-to-back start
                    // edge be caught right after the stop bit.
                    timer_nxt = '0;
                    state_nxt = IDLE;
                    if (rx_s) begin
                        byte_done = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                        armed_nxt = 1'b0;
                    end
                end else begin
                    timer_nxt = timer + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Holding register and handshake. A byte landing on the same edge as
    // rd_ack counts as consuming the old byte, so no overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= 8'h00;
            data_ready <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (byte_done) begin
                data_out   <= shift;
                data_ready <= 1'b1;
                if (data_ready && !rd_ack) overrun <= 1'b1;
            end else if (rd_ack) begin
                data_ready <= 1'b0;
            end
            if (frame_bad) frame_err <= 1'b1;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel receive stage; consumes the TxD line of the team's UART transmitter (8N1, LSB first, idle high).
- Recovers each frame using a single-clock bit timer with mid-bit sampling.
- Presents each received byte on a holding register with a ready/acknowledge handshake.
- Reports frame and overrun errors. Sits between the chip input pin (e.g. uio_in[x]) and downstream consumers such as a display or loopback logic.

Parameters:
- CLKS_PER_BIT, 10417, clk cycles per bit (100 MHz / 9600 baud); legal range 4..65535.
- CNT_W, 16, width of the bit-timer counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- RxD  input  1  serial line, asynchronous to clk, idle high.
- rd_ack  input  1  consumer acknowledge; clears data_ready.
- data_out  output  8  last correctly received byte.
- data_ready  output  1  high while data_out holds an unacknowledged byte.
- frame_err  output  1  sticky; set on bad stop bit.
- overrun  output  1  sticky; set when a byte is lost.
- busy  output  1  high while a frame is being received (any state except IDLE).

Behaviour:
- Reset (async, rst_n=0):
  - data_out=8'h00, data_ready=0, frame_err=0, overrun=0, busy=0.
  - Synchronizer flops = 1; state=IDLE; counters=0.
  - Reset mid-frame abandons the frame; no output updates.
- Input sync:
  - RxD passes through a 2-flop synchronizer to give rx_s.
  - All decisions use rx_s, so there are 2 cycles of input latency.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: on rx_s=0, go to START with timer=0.
  - START: count to (CLKS_PER_BIT-1)/2 (integer division), then sample.
    - rx_s=0: timer=0, bit_idx=0, go to DATA.
    - rx_s=1: glitch; return to IDLE with no flags.
  - DATA: after CLKS_PER_BIT cycles, sample rx_s into shift[bit_idx] (LSB first).
    - After bit_idx=7, go to STOP; otherwise increment bit_idx.
  - STOP: after CLKS_PER_BIT cycles, sample.
    - rx_s=1: valid frame. data_out<=shift and data_ready<=1 on the same edge. If data_ready was already 1 and rd_ack is not asserted that cycle, set overrun=1 (the new byte still overwrites data_out).
    - rx_s=0: frame_err<=1; data_out and data_ready are unchanged.
    - Either way, go to IDLE. If rx_s=0, IDLE re-arms only after rx_s is seen high (no false start on a break).
- Timer behaviour: the timer counts 0..CLKS_PER_BIT-1 and wraps to 0 at each sample point. Sampling lands at mid-bit ±1 cycle.
- Handshake:
  - rd_ack=1 with data_ready=1 clears data_ready on the next edge.
  - rd_ack while data_ready=0 is ignored.
  - If a new byte completes in the same cycle as rd_ack, data_ready stays 1 with the new byte, and no overrun is flagged.
- Sticky flags: frame_err and overrun clear only on reset.
- Back-to-back frames: a start bit directly after the stop sample is accepted, because IDLE is entered on the stop-bit midpoint.
- Latency: data_ready rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (±1) after the start-bit falling edge on RxD.
- busy=1 from the cycle START is entered through the cycle STOP exits.

Test Plan:
- Reset check (CLKS_PER_BIT=16): hold rst_n=0 with RxD=1, then release. All outputs are 0 and busy=0. Assert rst_n=0 mid-DATA: outputs stay 0, and the next frame 0x3C is received correctly.
- Single byte: send 0xA5 (8N1). data_out=8'hA5 and data_ready=1 about 154 cycles after the falling edge; frame_err=0. Pulse rd_ack: data_ready=0 on the next cycle.
- Loopback with the transmitter: drive it with ui_in=0x5A and Transmit pulsed, feeding TxD into RxD. data_out=0x5A, and both blocks use identical CLKS_PER_BIT.
- Glitch rejection: RxD low for 5 cycles (less than 8), then high. The FSM returns to IDLE, busy drops, and data_ready, frame_err and overrun all stay 0.
- Frame error: send 0x81 with the stop bit forced to 0, then RxD high. frame_err=1, data_ready=0, data_out unchanged. A following frame 0x42 is received (data_out=0x42) while frame_err stays 1.
- Overrun and simultaneous ack:
  - Send 0x11 then 0x22 back-to-back without rd_ack: overrun=1, data_out=0x22.
  - Repeat after reset with rd_ack asserted exactly on the cycle 0x22 completes: overrun=0, data_ready=1, data_out=0x22.
